if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Dual-issue instruction fetch unit on the IF side of the IF/ID instruction buffer.
- Generates the fetch PC and issues 8-byte-aligned requests to instruction memory. Splits each 64-bit response into two 32-bit instruction slots with their PCs, then pushes them into the buffer.
- Honours the buffer's full indication and redirects on branch_flag/branch_pc, discarding wrong-path fetches.
- Keeps at most one memory request outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- PC_W, 32, PC width.
- INST_W, 32, instruction width; memory data width is 2*INST_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- branch_flag  in  1  redirect request, one-cycle pulse.
- branch_pc  in  PC_W  redirect target; bits [1:0] ignored.
- instbuf_full  in  1  buffer cannot accept a further 2-instruction group.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  PC_W  fetch address, bits [2:0] always 0.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response data valid, one cycle.
- imem_rsp_data  in  2*INST_W  [31:0] = instruction at addr, [63:32] = instruction at addr+4.
- inst_out1, inst_out2  out  INST_W  slot 1 / slot 2 instruction to the buffer.
- inst_pc1, inst_pc2  out  PC_W  slot PCs.
- inst_valid1, inst_valid2  out  1  per-slot push strobes, one-cycle pulses.

Behaviour:
- Reset (rst=0, async) sets:
  - pc=RESET_PC, state=IDLE.
  - imem_req_valid=0, imem_req_addr=0.
  - inst_valid1=inst_valid2=0; inst_out*/inst_pc*=0.
  - Hold register empty.
- All outputs are registered.
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
- IDLE: imem_req_valid=0. Goes to REQ next cycle when instbuf_full=0.
- REQ:
  - imem_req_valid=1, imem_req_addr={pc[31:3],3'b000}.
  - Address is held stable until the handshake; the only exception is a redirect.
  - On valid&&ready: req_pc<=pc, pc<={pc[31:3],3'b000}+8 (wraps modulo 2^32), go to WAIT.
- WAIT, on imem_rsp_valid:
  - Form the group:
    - slot1 = data[31:0], pc1 = {req_pc[31:3],3'b000}, valid1 = ~req_pc[2].
    - slot2 = data[63:32], pc2 = pc1+4, valid2 = 1.
  - If instbuf_full=0: push the group and go to REQ.
  - Otherwise latch the group into the hold register and go to HOLD.
- Push timing: a decision in cycle t drives inst_valid* high in cycle t+1 only. Data and PC outputs keep their last value while the valids are low.
- HOLD: no requests. When instbuf_full=0, push the held group and go to REQ.
- Buffer contract: instbuf_full=0 in cycle t guarantees space for 2 entries at t+1.
- Redirect (branch_flag=1) has priority over every other event in that cycle:
  - pc<={branch_pc[31:2],2'b00}.
  - Any push decided in that cycle is suppressed, so no inst_valid at t+1.
  - Per-state effect:
    - REQ without handshake: stay in REQ; imem_req_addr takes the new target next cycle. Imem tolerates an address change before acceptance.
    - REQ with handshake in the same cycle: go to FLUSH.
    - WAIT without response: go to FLUSH.
    - WAIT with response: drop the data, go to REQ.
    - HOLD: drop the held group, go to REQ.
    - IDLE: stay in IDLE, pc updated.
    - FLUSH: stay in FLUSH, pc updated.
- FLUSH: no requests. The next imem_rsp_valid is discarded, then go to REQ.
- Target alignment: if the target has bit2=1, the first group after the redirect has valid1=0, valid2=1.
- Stray response: imem_rsp_valid in IDLE, REQ or HOLD is ignored. This is a protocol error, flagged by a bench assertion.
- Reset mid-operation: an in-flight response after reset release is ignored. The bench drives no response during reset.

Test Plan:
- Reset, instbuf_full=0, memory ready=1 with 1-cycle latency returning data {pc+4,pc}:
  - Requests at 0x0, 0x8, 0x10.
  - Pushes (pc1,pc2) = (0x0,0x4), (0x8,0xC), both valids high each time.
- branch_pc=0x104 pulsed while idle in REQ:
  - Next request addr 0x100.
  - Pushed group valid1=0, valid2=1, inst_pc2=0x104.
- instbuf_full=1 when a response arrives:
  - Group held, no request issued, no inst_valid.
  - Drop full: push occurs the cycle after full falls, then the request to the next address.
- branch_flag in WAIT before the response (target 0x200):
  - Old response discarded, no push.
  - Next request addr 0x200.
- branch_flag in the same cycle as rsp_valid:
  - No push that group.
  - Next request addr = branch target.
- rst asserted during WAIT:
  - Immediately imem_req_valid=0, inst_valid*=0.
  - After release, the first request is at RESET_PC.
- pc=0xFFFF_FFF8: the next request wraps to 0x0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: dual-issue instruction fetch unit feeding the IF/ID instruction buffer.
// Issues 8-byte-aligned fetches (one outstanding at most), splits each 64-bit
// response into two instruction slots with PCs, and pushes them into the buffer.
// Handles buffer back-pressure via a one-group hold register and branch
// redirects by discarding wrong-path responses.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   branch_flag, branch_pc       redirect pulse and target
//   instbuf_full                 buffer cannot take another 2-instruction group
//   imem_req_valid/addr/ready    fetch request handshake
//   imem_rsp_valid/data          fetch response (low word = lower address)
//   inst_out1/2, inst_pc1/2      slot instructions and PCs to the buffer
//   inst_valid1/2                per-slot push strobes (one-cycle pulses)
module if_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_flag,
  input  logic [PC_W-1:0]     branch_pc,
  input  logic                instbuf_full,
  output logic                imem_req_valid,
  output logic [PC_W-1:0]     imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [2*INST_W-1:0] imem_rsp_data,
  output logic [INST_W-1:0]   inst_out1,
  output logic [INST_W-1:0]   inst_out2,
  output logic [PC_W-1:0]     inst_pc1,
  output logic [PC_W-1:0]     inst_pc2,
  output logic                inst_valid1,
  output logic                inst_valid2
);

  localparam int unsigned DATA_W = 2 * INST_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]        state, state_d;
  logic [PC_W-1:0]   pc, pc_d;
  logic [PC_W-1:0]   req_pc, req_pc_d;
  logic              req_valid_d;
  logic [PC_W-1:0]   req_addr_d;
  logic [INST_W-1:0] out1_d, out2_d;
  logic [PC_W-1:0]   pc1_d, pc2_d;
  logic              valid1_d, valid2_d;

  // Hold register: one complete group parked while the buffer is full.
  logic              hold_valid, hold_valid_d;
  logic [INST_W-1:0] hold_inst1, hold_inst1_d;
  logic [INST_W-1:0] hold_inst2, hold_inst2_d;
  logic [PC_W-1:0]   hold_pc1, hold_pc1_d;
  logic              hold_v1, hold_v1_d;

  // Group formed from the current response and the PC that requested it.
  logic [INST_W-1:0] grp_inst1, grp_inst2;
  logic [PC_W-1:0]   grp_pc1;
  logic              grp_v1;
  logic              handshake;

  assign grp_inst1 = imem_rsp_data[INST_W-1:0];
  assign grp_inst2 = imem_rsp_data[DATA_W-1:INST_W];
  assign grp_pc1   = {req_pc[PC_W-1:3], 3'b000};
  // A request made for an odd-word PC (redirect target) skips slot 1.
  assign grp_v1    = ~req_pc[2];
  assign handshake = imem_req_valid & imem_req_ready;

  // Address low bits carry no information at this point.
  logic unused_bits;
  assign unused_bits = &{1'b0, branch_pc[1:0], req_pc[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    req_pc_d     = req_pc;
    req_valid_d  = 1'b0;
    req_addr_d   = imem_req_addr;
    out1_d       = inst_out1;
    out2_d       = inst_out2;
    pc1_d        = inst_pc1;
    pc2_d        = inst_pc2;
    valid1_d     = 1'b0;
    valid2_d     = 1'b0;
    hold_valid_d = hold_valid;
    hold_inst1_d = hold_inst1;
    hold_inst2_d = hold_inst2;
    hold_pc1_d   = hold_pc1;
    hold_v1_d    = hold_v1;

    case (state)
      S_IDLE: begin
        if (!branch_flag && !instbuf_full) state_d = S_REQ;
      end
      S_REQ: begin
        if (handshake) begin
          req_pc_d = pc;
          pc_d     = {pc[PC_W-1:3], 3'b000} + PC_W'(8);
          // Accepted request is already wrong-path if redirected this cycle.
          state_d  = branch_flag ? S_FLUSH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (branch_flag) begin
            state_d = S_REQ;
          end else if (!instbuf_full) begin
            out1_d   = grp_inst1;
            out2_d   = grp_inst2;
            pc1_d    = grp_pc1;
            pc2_d    = grp_pc1 + PC_W'(4);
            valid1_d = grp_v1;
            valid2_d = 1'b1;
            state_d  = S_REQ;
          end else begin
            hold_valid_d = 1'b1;
            hold_inst1_d = grp_inst1;
            hold_inst2_d = grp_inst2;
            hold_pc1_d   = grp_pc1;
            hold_v1_d    = grp_v1;
            state_d      = S_HOLD;
          end
        end else if (branch_flag) begin
          state_d = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (branch_flag) begin
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (!instbuf_full && hold_valid) begin
          out1_d       = hold_inst1;
          out2_d       = hold_inst2;
          pc1_d        = hold_pc1;
          pc2_d        = hold_pc1 + PC_W'(4);
          valid1_d     = hold_v1;
          valid2_d     = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_FLUSH: begin
        // The wrong-path response retires the flush even if a further
        // redirect lands in the same cycle; only one request is ever in flight.
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_flag) pc_d = {branch_pc[PC_W-1:2], 2'b00};

    // Request outputs follow the state being entered, so they are registered.
    if (state_d == S_REQ) begin
      req_valid_d = 1'b1;
      req_addr_d  = {pc_d[PC_W-1:3], 3'b000};
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_PC;
      req_pc         <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
      inst_out1      <= '0;
      inst_out2      <= '0;
      inst_pc1       <= '0;
      inst_pc2       <= '0;
      inst_valid1    <= 1'b0;
      inst_valid2    <= 1'b0;
      hold_valid     <= 1'b0;
      hold_inst1     <= '0;
      hold_inst2     <= '0;
      hold_pc1       <= '0;
      hold_v1        <= 1'b0;
    end else begin
      pc             <= pc_d;
      req_pc         <= req_pc_d;
      imem_req_valid <= req_valid_d;
      imem_req_addr  <= req_addr_d;
      inst_out1      <= out1_d;
      inst_out2      <= out2_d;
      inst_pc1       <= pc1_d;
      inst_pc2       <= pc2_d;
      inst_valid1    <= valid1_d;
      inst_valid2    <= valid2_d;
      hold_valid     <= hold_valid_d;
      hold_inst1     <= hold_inst1_d;
      hold_inst2     <= hold_inst2_d;
      hold_pc1       <= hold_pc1_d;
      hold_v1        <= hold_v1_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: cycle-accurate directed test of if_fetch. Each table row gives
// one cycle of inputs and the outputs expected after the following clock edge.
// Response data for fetch address a is {B000_0000+a+4, A000_0000+a}.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_pc;
  logic        instbuf_full;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic [31:0] inst_out1, inst_out2, inst_pc1, inst_pc2;
  logic        inst_valid1, inst_valid2;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .branch_flag    (branch_flag),
    .branch_pc      (branch_pc),
    .instbuf_full   (instbuf_full),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_out1      (inst_out1),
    .inst_out2      (inst_out2),
    .inst_pc1       (inst_pc1),
    .inst_pc2       (inst_pc2),
    .inst_valid1    (inst_valid1),
    .inst_valid2    (inst_valid2)
  );

  typedef struct {
    logic        br;
    logic [31:0] bpc;
    logic        full;
    logic        rdy;
    logic        rsp;
    logic [31:0] raddr;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_v1;
    logic        e_v2;
    logic [31:0] e_pc1;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Protocol monitor: a response is only legal while a request is outstanding.
  logic outstanding;
  bit   stray_ok = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) outstanding <= 1'b0;
    else begin
      if (imem_rsp_valid) outstanding <= 1'b0;
      if (imem_req_valid && imem_req_ready) outstanding <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst && imem_rsp_valid && !stray_ok) begin
      tests++;
      assert (outstanding) else begin
        fails++;
        $display("FAIL stray_rsp: response with no request outstanding at %0t", $time);
      end
    end
  end

  function automatic logic [63:0] rdata(input logic [31:0] a);
    return {32'hB000_0000 + a + 32'd4, 32'hA000_0000 + a};
  endfunction

  function automatic vec_t mk(input logic br, input logic [31:0] bpc, input logic full,
                              input logic rdy, input logic rsp, input logic [31:0] raddr,
                              input logic e_rv, input logic [31:0] e_ra,
                              input logic e_v1, input logic e_v2, input logic [31:0] e_pc1);
    vec_t v;
    v.br = br; v.bpc = bpc; v.full = full; v.rdy = rdy; v.rsp = rsp; v.raddr = raddr;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_pc1 = e_pc1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock, then check outputs on the falling edge.
  task automatic step(input vec_t v, input string tag);
    branch_flag    = v.br;
    branch_pc      = v.bpc;
    instbuf_full   = v.full;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rsp;
    imem_rsp_data  = v.rsp ? rdata(v.raddr) : 64'h0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.e_rv));
    chk({tag, " req_addr"},  imem_req_addr,       v.e_ra);
    chk({tag, " valid1"},    32'(inst_valid1),    32'(v.e_v1));
    chk({tag, " valid2"},    32'(inst_valid2),    32'(v.e_v2));
    if (v.e_v1 || v.e_v2) begin
      chk({tag, " pc1"},   inst_pc1,  v.e_pc1);
      chk({tag, " pc2"},   inst_pc2,  v.e_pc1 + 32'd4);
      chk({tag, " inst1"}, inst_out1, 32'hA000_0000 + v.e_pc1);
      chk({tag, " inst2"}, inst_out2, 32'hB000_0000 + v.e_pc1 + 32'd4);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, " req_addr"},  imem_req_addr,       32'd0);
    chk({tag, " valid1"},    32'(inst_valid1),    32'd0);
    chk({tag, " valid2"},    32'(inst_valid2),    32'd0);
    chk({tag, " inst_out1"}, inst_out1,           32'd0);
    chk({tag, " inst_pc2"},  inst_pc2,            32'd0);
  endtask

  initial begin
    //               br bpc           full rdy rsp raddr         rv ra            v1 v2 pc1
    // Straight-line fetch: 0x0, 0x8, 0x10.
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h0,         1, 32'h8,         1, 1, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h8,         0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h8,         1, 32'h10,        1, 1, 32'h8));
    // Redirect to 0x104 while REQ is stalled; first group has slot 1 invalid.
    vecs.push_back(mk(1, 32'h104,       0, 0, 0, 32'h0,         1, 32'h100,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h100,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h100,       1, 32'h108,       0, 1, 32'h100));
    // Buffer full on response: hold, then push when full drops.
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h108,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 1, 1, 32'h108,       0, 32'h108,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h108,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h110,       1, 1, 32'h108));
    // Redirect in WAIT before the response: flush, then fetch 0x200.
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h110,       0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h200,       0, 1, 0, 32'h0,         0, 32'h110,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h110,       1, 32'h200,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h200,       0, 0, 32'h0));
    // Redirect together with the response: drop it, fetch the target.
    vecs.push_back(mk(1, 32'h300,       0, 1, 1, 32'h200,       1, 32'h300,       0, 0, 32'h0));
    // Redirect in the handshake cycle: flush, then odd-word target 0x40C.
    vecs.push_back(mk(1, 32'h40F,       0, 1, 0, 32'h0,         0, 32'h300,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h300,       1, 32'h408,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h408,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'h408,       1, 32'h410,       0, 1, 32'h408));
    // Redirect while holding: held group is dropped.
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h410,       0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 1, 1, 32'h410,       0, 32'h410,       0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h500,       1, 1, 0, 32'h0,         1, 32'h500,       0, 0, 32'h0));
    // Top of address space: next request wraps to 0.
    vecs.push_back(mk(1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'hFFFF_FFF8, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 32'hFFFF_FFF8, 1, 32'h0,         1, 1, 32'hFFFF_FFF8));

    rst            = 1'b0;
    branch_flag    = 1'b0;
    branch_pc      = '0;
    instbuf_full   = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Async reset with pushes and a request visible: outputs clear at once.
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(mk(0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h0, 0, 0, 32'h0), "rst1_req");
    step(mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0), "rst1_hs");

    // Reset during WAIT; the late response after release must be ignored.
    rst = 1'b0;
    #1;
    chk_reset_outputs("wait_rst");
    @(negedge clk);
    rst = 1'b1;
    stray_ok = 1'b1;
    step(mk(0, 32'h0, 0, 1, 1, 32'h20, 1, 32'h0, 0, 0, 32'h0), "rst2_stray");
    stray_ok = 1'b0;
    step(mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0), "rst2_hs");
    step(mk(0, 32'h0, 0, 1, 1, 32'h0, 1, 32'h8, 1, 1, 32'h0), "rst2_push");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
